// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler that shares one external adder between two FWFT input FIFOs.
// Each granted word drives the adder, waits ADD_LATENCY cycles, then writes a source-tagged sum.
module adder_rr_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 4,
  parameter int ADD_LATENCY = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ch0_empty,
  output logic                  ch0_rd,
  input  logic [DATA_WIDTH-1:0] ch0_din,
  input  logic                  ch1_empty,
  output logic                  ch1_rd,
  input  logic [DATA_WIDTH-1:0] ch1_din,
  input  logic                  data_full,
  output logic                  data_wr,
  output logic [DATA_WIDTH-1:0] data_dout,
  output logic [OP_WIDTH-1:0]   add_in1,
  output logic [OP_WIDTH-1:0]   add_in2,
  input  logic [OP_WIDTH:0]     add_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  ch0_done_cnt,
  output logic [CNT_WIDTH-1:0]  ch1_done_cnt
);
  localparam int LAT_W = $clog2(ADD_LATENCY + 1);
  localparam int PAD_W = DATA_WIDTH - OP_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  state_t                state_reg, state_next;
  logic                  last_grant_reg, last_grant_next;
  logic                  src_reg, src_next;
  logic [LAT_W-1:0]      cnt_reg, cnt_next;
  logic [OP_WIDTH:0]     sum_reg, sum_next;
  logic                  ch0_rd_reg, ch0_rd_next;
  logic                  ch1_rd_reg, ch1_rd_next;
  logic                  data_wr_reg, data_wr_next;
  logic [DATA_WIDTH-1:0] data_dout_reg, data_dout_next;
  logic [OP_WIDTH-1:0]   add_in1_reg, add_in1_next;
  logic [OP_WIDTH-1:0]   add_in2_reg, add_in2_next;
  logic                  busy_reg, busy_next;
  logic [CNT_WIDTH-1:0]  ch0_done_reg, ch0_done_next;
  logic [CNT_WIDTH-1:0]  ch1_done_reg, ch1_done_next;

  logic                  grant_valid;
  logic                  grant_ch;
  logic [2*OP_WIDTH-1:0] grant_ops;

  // Only the two operand fields of a FIFO word are meaningful.
  logic unused_din_bits;
  assign unused_din_bits = ^{ch0_din[DATA_WIDTH-1:2*OP_WIDTH], ch1_din[DATA_WIDTH-1:2*OP_WIDTH]};

  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = 1'b0;
    if (!ch0_empty && !ch1_empty) begin
      grant_valid = 1'b1;
      grant_ch    = ~last_grant_reg;
    end else if (!ch0_empty) begin
      grant_valid = 1'b1;
      grant_ch    = 1'b0;
    end else if (!ch1_empty) begin
      grant_valid = 1'b1;
      grant_ch    = 1'b1;
    end
    grant_ops = grant_ch ? ch1_din[2*OP_WIDTH-1:0] : ch0_din[2*OP_WIDTH-1:0];
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    src_next        = src_reg;
    cnt_next        = cnt_reg;
    sum_next        = sum_reg;
    ch0_rd_next     = 1'b0;
    ch1_rd_next     = 1'b0;
    data_wr_next    = 1'b0;
    data_dout_next  = data_dout_reg;
    add_in1_next    = add_in1_reg;
    add_in2_next    = add_in2_reg;
    ch0_done_next   = ch0_done_reg;
    ch1_done_next   = ch1_done_reg;

    case (state_reg)
      S_IDLE: begin
        if (grant_valid) begin
          ch0_rd_next  = ~grant_ch;
          ch1_rd_next  = grant_ch;
          add_in1_next = grant_ops[OP_WIDTH-1:0];
          add_in2_next = grant_ops[2*OP_WIDTH-1:OP_WIDTH];
          src_next     = grant_ch;
          cnt_next     = LAT_W'(ADD_LATENCY);
          state_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        // cnt==1 marks the edge ADD_LATENCY cycles after the operands were registered.
        if (cnt_reg == LAT_W'(1)) begin
          sum_next   = add_out;
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!data_full) begin
          data_wr_next    = 1'b1;
          data_dout_next  = {src_reg, {PAD_W{1'b0}}, sum_reg};
          last_grant_next = src_reg;
          if (src_reg) ch1_done_next = ch1_done_reg + 1'b1;
          else         ch0_done_next = ch0_done_reg + 1'b1;
          state_next      = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= 1'b1;
      src_reg        <= 1'b0;
      cnt_reg        <= '0;
      sum_reg        <= '0;
      ch0_rd_reg     <= 1'b0;
      ch1_rd_reg     <= 1'b0;
      data_wr_reg    <= 1'b0;
      data_dout_reg  <= '0;
      add_in1_reg    <= '0;
      add_in2_reg    <= '0;
      busy_reg       <= 1'b0;
      ch0_done_reg   <= '0;
      ch1_done_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      src_reg        <= src_next;
      cnt_reg        <= cnt_next;
      sum_reg        <= sum_next;
      ch0_rd_reg     <= ch0_rd_next;
      ch1_rd_reg     <= ch1_rd_next;
      data_wr_reg    <= data_wr_next;
      data_dout_reg  <= data_dout_next;
      add_in1_reg    <= add_in1_next;
      add_in2_reg    <= add_in2_next;
      busy_reg       <= busy_next;
      ch0_done_reg   <= ch0_done_next;
      ch1_done_reg   <= ch1_done_next;
    end
  end

  assign ch0_rd       = ch0_rd_reg;
  assign ch1_rd       = ch1_rd_reg;
  assign data_wr      = data_wr_reg;
  assign data_dout    = data_dout_reg;
  assign add_in1      = add_in1_reg;
  assign add_in2      = add_in2_reg;
  assign busy         = busy_reg;
  assign ch0_done_cnt = ch0_done_reg;
  assign ch1_done_cnt = ch1_done_reg;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Scoreboard bench for adder_rr_scheduler: instance 0 uses a 1-cycle adder, instance 1 a
// 3-cycle adder with 4-bit completion counters.
module tb_adder_rr_scheduler;
  localparam int DW   = 32;
  localparam int OW   = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int CW0  = 16;
  localparam int CW1  = 4;

  logic          clock = 1'b0;
  logic          rst_n     [2];
  logic          ch_empty  [2][2];
  logic [DW-1:0] ch_din    [2][2];
  logic          ch_rd     [2][2];
  logic          data_full [2];
  logic          data_wr   [2];
  logic [DW-1:0] data_dout [2];
  logic [OW-1:0] add_in1   [2];
  logic [OW-1:0] add_in2   [2];
  logic [OW:0]   add_out   [2];
  logic          busy      [2];
  logic [15:0]   done_cnt  [2][2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] fifo_q     [2][2][$];
  logic [DW-1:0] exp_q      [2][2][$];
  logic [DW-1:0] flight_q   [2][$];
  int            flight_cyc [2][$];
  int            grant_log  [2][$];
  int            rd_count   [2] = '{0, 0};
  int            wr_count   [2] = '{0, 0};
  int            exp_cnt    [2][2] = '{'{0, 0}, '{0, 0}};
  bit            stall_mode [2] = '{1'b0, 1'b0};
  bit            mon_en     [2] = '{1'b0, 1'b0};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int L  = (gi == 0) ? LAT0 : LAT1;
    localparam int CW = (gi == 0) ? CW0 : CW1;
    logic [CW-1:0] cnt0, cnt1;

    adder_rr_scheduler #(
      .DATA_WIDTH (DW),
      .OP_WIDTH   (OW),
      .ADD_LATENCY(L),
      .CNT_WIDTH  (CW)
    ) dut (
      .clock       (clock),
      .reset_n     (rst_n[gi]),
      .ch0_empty   (ch_empty[gi][0]),
      .ch0_rd      (ch_rd[gi][0]),
      .ch0_din     (ch_din[gi][0]),
      .ch1_empty   (ch_empty[gi][1]),
      .ch1_rd      (ch_rd[gi][1]),
      .ch1_din     (ch_din[gi][1]),
      .data_full   (data_full[gi]),
      .data_wr     (data_wr[gi]),
      .data_dout   (data_dout[gi]),
      .add_in1     (add_in1[gi]),
      .add_in2     (add_in2[gi]),
      .add_out     (add_out[gi]),
      .busy        (busy[gi]),
      .ch0_done_cnt(cnt0),
      .ch1_done_cnt(cnt1)
    );

    assign done_cnt[gi][0] = 16'(cnt0);
    assign done_cnt[gi][1] = 16'(cnt1);

    // Adder model: result is valid L cycles after the operands change.
    if (L == 1) begin : g_add
      assign add_out[gi] = {1'b0, add_in1[gi]} + {1'b0, add_in2[gi]};
    end else begin : g_add
      logic [OW:0] pipe [L-1];
      always @(posedge clock) begin
        pipe[0] <= {1'b0, add_in1[gi]} + {1'b0, add_in2[gi]};
        for (int k = 1; k < L - 1; k++) pipe[k] <= pipe[k-1];
      end
      assign add_out[gi] = pipe[L-2];
    end
  end

  // FWFT FIFO models: pop on a sampled rd strobe, flags refreshed half a cycle later.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++)
        if (ch_rd[i][c] && fifo_q[i][c].size() != 0) void'(fifo_q[i][c].pop_front());
  end

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) begin
        ch_empty[i][c] = (fifo_q[i][c].size() == 0);
        ch_din[i][c]   = (fifo_q[i][c].size() == 0) ? '0 : fifo_q[i][c][0];
      end
  end

  task automatic check_val(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int mask_of(input int i);
    return (i == 0) ? 32'h0000_FFFF : 32'h0000_000F;
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] w, input int ch);
    logic [OW:0] s;
    s = {1'b0, w[OW-1:0]} + {1'b0, w[2*OW-1:OW]};
    return {ch[0], {(DW-OW-2){1'b0}}, s};
  endfunction

  task automatic push_word(input int i, input int ch, input logic [DW-1:0] w);
    fifo_q[i][ch].push_back(w);
    exp_q[i][ch].push_back(exp_word(w, ch));
  endtask

  // Monitor and scoreboard.
  always @(negedge clock) begin
    logic [DW-1:0] e;
    int rc;
    int ch;
    for (int i = 0; i < 2; i++) begin
      if (mon_en[i]) begin
        for (int c = 0; c < 2; c++) begin
          if (ch_rd[i][c]) begin
            rd_count[i]++;
            grant_log[i].push_back(c);
            check_val("busy_on_rd", busy[i], 1);
            if (exp_q[i][c].size() == 0) check_val("rd_unexpected", 1, 0);
            else begin
              flight_q[i].push_back(exp_q[i][c].pop_front());
              flight_cyc[i].push_back(cyc);
            end
          end
        end
        if (data_wr[i]) begin
          wr_count[i]++;
          check_val("busy_after_wr", busy[i], 0);
          if (flight_q[i].size() == 0) check_val("wr_unexpected", 1, 0);
          else begin
            e  = flight_q[i].pop_front();
            rc = flight_cyc[i].pop_front();
            ch = int'(e[DW-1]);
            $display("inst%0d cyc=%0d wr ch%0d dout=%h want=%h", i, cyc, ch, data_dout[i], e);
            check_val("dout", data_dout[i], e);
            if (!stall_mode[i]) check_val("pop_to_wr_latency", cyc - rc, lat_of(i) + 1);
            exp_cnt[i][ch]++;
            check_val("ch0_done_cnt", done_cnt[i][0], exp_cnt[i][0] & mask_of(i));
            check_val("ch1_done_cnt", done_cnt[i][1], exp_cnt[i][1] & mask_of(i));
          end
        end
      end
    end
  end

  // Reset is dropped mid-cycle so the async clear is observed before any clock edge.
  task automatic do_reset(input int i);
    @(negedge clock);
    mon_en[i] = 1'b0;
    #2;
    rst_n[i] = 1'b0;
    #1;
    check_val("rst_ch0_rd", ch_rd[i][0], 0);
    check_val("rst_ch1_rd", ch_rd[i][1], 0);
    check_val("rst_data_wr", data_wr[i], 0);
    check_val("rst_data_dout", data_dout[i], 0);
    check_val("rst_add_in1", add_in1[i], 0);
    check_val("rst_add_in2", add_in2[i], 0);
    check_val("rst_busy", busy[i], 0);
    check_val("rst_ch0_cnt", done_cnt[i][0], 0);
    check_val("rst_ch1_cnt", done_cnt[i][1], 0);
    for (int c = 0; c < 2; c++) begin
      fifo_q[i][c].delete();
      exp_q[i][c].delete();
      exp_cnt[i][c] = 0;
    end
    flight_q[i].delete();
    flight_cyc[i].delete();
    grant_log[i].delete();
    repeat (2) @(negedge clock);
    rst_n[i]  = 1'b1;
    mon_en[i] = 1'b1;
  endtask

  task automatic drain(input int i, input int budget);
    int n = 0;
    while ((fifo_q[i][0].size() + fifo_q[i][1].size() + flight_q[i].size()) != 0 || busy[i]) begin
      @(negedge clock);
      #1;
      n++;
      if (n > budget) begin
        check_val("drain_timeout", n, budget);
        break;
      end
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_rd(input int i, input int start, input int budget);
    int n = 0;
    while (rd_count[i] == start) begin
      @(negedge clock);
      #1;
      n++;
      if (n > budget) begin
        check_val("rd_timeout", n, budget);
        break;
      end
    end
  endtask

  initial begin
    int s_rd;
    int s_wr;
    logic [DW-1:0] w;
    rst_n[0]     = 1'b1;
    rst_n[1]     = 1'b1;
    data_full[0] = 1'b0;
    data_full[1] = 1'b0;

    // Single ch0 op with a 1-cycle adder.
    do_reset(0);
    push_word(0, 0, 32'h0000_00F7);
    drain(0, 50);
    check_val("t1_dout", data_dout[0], 32'h0000_0016);
    check_val("t1_ch0_cnt", done_cnt[0][0], 1);

    // Both channels pending right after reset: ch0 wins the first tie, then alternation.
    do_reset(0);
    push_word(0, 0, 32'h0000_0021);
    push_word(0, 1, 32'h0000_0043);
    push_word(0, 0, 32'h0000_0021);
    push_word(0, 1, 32'h0000_0043);
    drain(0, 100);
    check_val("t2_grants", grant_log[0].size(), 4);
    if (grant_log[0].size() == 4) begin
      check_val("t2_grant0", grant_log[0][0], 0);
      check_val("t2_grant1", grant_log[0][1], 1);
      check_val("t2_grant2", grant_log[0][2], 0);
      check_val("t2_grant3", grant_log[0][3], 1);
    end
    check_val("t2_last_dout", data_dout[0], 32'h8000_0007);
    check_val("t2_ch0_cnt", done_cnt[0][0], 2);
    check_val("t2_ch1_cnt", done_cnt[0][1], 2);

    // Output full held through WRITE: nothing written, nothing popped.
    stall_mode[0] = 1'b1;
    data_full[0]  = 1'b1;
    s_rd = rd_count[0];
    s_wr = wr_count[0];
    push_word(0, 0, 32'h0000_0055);
    push_word(0, 1, 32'h0000_0012);
    wait_rd(0, s_rd, 20);
    repeat (LAT0 + 1) @(negedge clock);
    repeat (10) @(negedge clock);
    #1;
    check_val("t3_stall_no_wr", wr_count[0], s_wr);
    check_val("t3_stall_no_rd", rd_count[0], s_rd + 1);
    check_val("t3_stall_busy", busy[0], 1);
    data_full[0] = 1'b0;
    drain(0, 50);
    check_val("t3_wr_after_stall", wr_count[0], s_wr + 2);
    check_val("t3_last_dout", data_dout[0], 32'h8000_0003);

    // Random traffic with random back-pressure.
    for (int k = 0; k < 40; k++) begin
      push_word(0, int'($urandom_range(0, 1)), $urandom());
      data_full[0] = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 4)) @(negedge clock);
    end
    data_full[0] = 1'b0;
    drain(0, 600);
    stall_mode[0] = 1'b0;

    // 3-cycle adder, 4-bit counters: 17 ch1 ops wrap ch1_done_cnt to 1.
    do_reset(1);
    for (int k = 0; k < 17; k++) push_word(1, 1, $urandom());
    drain(1, 200);
    check_val("t6_ch1_cnt_wrap", done_cnt[1][1], 1);
    check_val("t6_ch0_cnt", done_cnt[1][0], 0);

    // All 256 operand pairs, upper word bits randomised.
    for (int k = 0; k < 256; k++) begin
      w = $urandom();
      w[7:0] = k[7:0];
      push_word(1, k % 2, w);
    end
    drain(1, 2000);

    // Reset while waiting on the adder; the next op starts from IDLE with ch0 priority.
    s_rd = rd_count[1];
    push_word(1, 1, 32'h0000_0099);
    wait_rd(1, s_rd, 20);
    check_val("t4_busy_before_reset", busy[1], 1);
    do_reset(1);
    push_word(1, 0, 32'h0000_0021);
    push_word(1, 1, 32'h0000_0043);
    drain(1, 100);
    check_val("t4_grants", grant_log[1].size(), 2);
    if (grant_log[1].size() == 2) begin
      check_val("t4_grant0", grant_log[1][0], 0);
      check_val("t4_grant1", grant_log[1][1], 1);
    end
    check_val("t4_ch0_cnt", done_cnt[1][0], 1);
    check_val("t4_ch1_cnt", done_cnt[1][1], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
